// File: rtl/beep_scheduler_if.sv
// Buzzer request/grant bundle shared between the requesters (master) and beep_scheduler (slave).
interface beep_scheduler_if;
  logic [3:0]  req;
  logic [7:0]  rate_sel;
  logic [15:0] beep_cnt;
  logic [3:0]  grant;
  logic        busy;
  logic [3:0]  done;
  logic [3:0]  abort;
  logic        beep_out;

  modport master (output req, rate_sel, beep_cnt,
                  input  grant, busy, done, abort, beep_out);
  modport slave  (input  req, rate_sel, beep_cnt,
                  output grant, busy, done, abort, beep_out);
endinterface

// File: rtl/beep_scheduler.sv
// Fixed-priority buzzer arbiter and beep sequencer for 4 requesters.
// Optional preemption by higher-priority requesters: define BEEP_PREEMPT_EN.
module beep_scheduler #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic          clk,
  input  logic          rst,
  beep_scheduler_if.slave bus
);
  localparam int N  = 4;
  localparam int CW = $clog2(CLK_HZ/4 + 1);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_e;

  state_e         state_q;
  logic [N-1:0]   grant_q, done_q, abort_q, served_q;
  logic           beep_q;
  logic [1:0]     owner_q, rate_q;
  logic [3:0]     rem_q;
  logic           cont_q;
  logic [CW-1:0]  hcnt_q;

  logic [N-1:0]   elig_d;
  logic           win_vld_d;
  logic [1:0]     win_idx_d;
  logic [1:0]     win_rate_d;
  logic [3:0]     win_cnt_d;

  // Half-period minus one; the H counter runs H-1 down to 0.
  function automatic logic [CW-1:0] hmax(input logic [1:0] r);
    case (r)
      2'd0:    hmax = CW'(CLK_HZ/4  - 1);
      2'd1:    hmax = CW'(CLK_HZ/6  - 1);
      2'd2:    hmax = CW'(CLK_HZ/8  - 1);
      default: hmax = CW'(CLK_HZ/16 - 1);
    endcase
  endfunction

  assign elig_d = bus.req & ~served_q;

  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (elig_d[k]) begin
        win_vld_d = 1'b1;
        win_idx_d = 2'(k);
      end
    end
  end

  assign win_rate_d = bus.rate_sel[{win_idx_d, 1'b0} +: 2];
  assign win_cnt_d  = bus.beep_cnt[{win_idx_d, 2'b00} +: 4];

`ifdef BEEP_PREEMPT_EN
  logic [N-1:0] lower_mask_d;
  assign lower_mask_d = (N'(1) << owner_q) - N'(1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      abort_q  <= '0;
      served_q <= '0;
      beep_q   <= 1'b0;
      owner_q  <= '0;
      rate_q   <= '0;
      rem_q    <= '0;
      cont_q   <= 1'b0;
      hcnt_q   <= '0;
    end else begin
      done_q   <= '0;
      abort_q  <= '0;
      served_q <= served_q & bus.req;
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            state_q <= ON;
            grant_q <= N'(1) << win_idx_d;
            beep_q  <= 1'b1;
            owner_q <= win_idx_d;
            rate_q  <= win_rate_d;
            rem_q   <= win_cnt_d;
            cont_q  <= (win_cnt_d == 4'd0);
            hcnt_q  <= hmax(win_rate_d);
          end
        end
        default: begin
          // Owner withdrew: abandon the partial beep and report done.
          if (!bus.req[owner_q]) begin
            state_q <= IDLE;
            grant_q <= '0;
            beep_q  <= 1'b0;
            done_q  <= grant_q;
          end
`ifdef BEEP_PREEMPT_EN
          else if (|(elig_d & lower_mask_d)) begin
            state_q <= IDLE;
            grant_q <= '0;
            beep_q  <= 1'b0;
            abort_q <= grant_q;
          end
`endif
          else if (hcnt_q != '0) begin
            hcnt_q <= hcnt_q - 1'b1;
          end else if (state_q == ON) begin
            state_q <= OFF;
            beep_q  <= 1'b0;
            hcnt_q  <= hmax(rate_q);
          end else if (!cont_q && rem_q == 4'd1) begin
            // Served mask stops a still-held req from retriggering.
            state_q  <= IDLE;
            grant_q  <= '0;
            done_q   <= grant_q;
            served_q <= (served_q & bus.req) | grant_q;
          end else begin
            if (!cont_q) rem_q <= rem_q - 4'd1;
            state_q <= ON;
            beep_q  <= 1'b1;
            hcnt_q  <= hmax(rate_q);
          end
        end
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.busy     = |grant_q;
  assign bus.done     = done_q;
  assign bus.beep_out = beep_q;
`ifdef BEEP_PREEMPT_EN
  assign bus.abort    = abort_q;
`else
  assign bus.abort    = '0;
  logic unused_abort;
  assign unused_abort = ^abort_q;
`endif

endmodule

// File: tb/tb_beep_scheduler.sv
// Self-checking bench for beep_scheduler at CLK_HZ=48 (H = 12,8,6,3 cycles).
module tb_beep_scheduler;
  localparam int CLK_HZ = 48;

  logic clk = 1'b0;
  logic rst = 1'b1;
  beep_scheduler_if bus();
  beep_scheduler #(.CLK_HZ(CLK_HZ)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference: half-period in cycles straight from the beeps-per-second table.
  function automatic int half(input int r);
    int bps;
    bps = (r == 0) ? 2 : (r == 1) ? 3 : (r == 2) ? 4 : 8;
    return CLK_HZ / (2 * bps);
  endfunction

  // Reference: buzzer level k cycles into a sequence with half-period h.
  function automatic logic lvl(input int k, input int h);
    return ((k / h) % 2) == 0;
  endfunction

  task automatic set_cfg(input int i, input int r, input int n);
    bus.rate_sel[2*i +: 2] = 2'(r);
    bus.beep_cnt[4*i +: 4] = 4'(n);
  endtask

  task automatic test_reset;
    logic [10:0] got;
    bus.req = '0; bus.rate_sel = '0; bus.beep_cnt = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    got = {bus.grant, bus.busy, bus.done, bus.abort, bus.beep_out};
    checks++;
    if (got !== 11'd0) $display("FAIL reset got=%b exp=0", got); else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sequences;
    for (int it = 0; it < 8; it++) begin
      int i, r, n, h, t;
      logic [3:0] oh;
      logic [13:0] got, exp;
      if (it == 0) begin i = 2; r = 3; n = 2; end
      else begin i = $urandom_range(3); r = $urandom_range(3); n = $urandom_range(4, 1); end
      h = half(r); t = 2 * h * n; oh = 4'b0001 << i;
      bus.rate_sel = 8'($urandom); bus.beep_cnt = 16'($urandom);
      set_cfg(i, r, n);
      bus.req = oh;
      for (int k = 0; k <= t; k++) begin
        @(negedge clk);
        if (k == 2) bus.rate_sel = 8'($urandom);
        got = {bus.grant, bus.busy, bus.done, bus.abort, bus.beep_out};
        exp = (k < t) ? {oh, 1'b1, 4'b0, 4'b0, lvl(k, h)} : {4'b0, 1'b0, oh, 4'b0, 1'b0};
        checks++;
        if (got !== exp) $display("FAIL seq it=%0d k=%0d got=%b exp=%b", it, k, got, exp);
        else passed++;
      end
      bus.req = '0;
      @(negedge clk);
    end
  endtask

  task automatic test_priority;
    int r0, r1, n0, n1, h0, h1, t0, t1;
    logic [8:0] got, exp;
    r0 = $urandom_range(3); r1 = $urandom_range(3);
    n0 = $urandom_range(3, 1); n1 = $urandom_range(3, 1);
    h0 = half(r0); h1 = half(r1); t0 = 2*h0*n0; t1 = 2*h1*n1;
    set_cfg(0, r0, n0); set_cfg(1, r1, n1);
    bus.req = 4'b0011;
    for (int k = 0; k <= t0 + t1 + 4; k++) begin
      @(negedge clk);
      if (k < t0)               exp = {4'b0001, 4'b0, lvl(k, h0)};
      else if (k == t0)         exp = {4'b0, 4'b0001, 1'b0};
      else if (k <= t0 + t1)    exp = {4'b0010, 4'b0, lvl(k - t0 - 1, h1)};
      else if (k == t0 + t1 + 1) exp = {4'b0, 4'b0010, 1'b0};
      else                      exp = 9'd0;
      got = {bus.grant, bus.done, bus.beep_out};
      checks++;
      if (got !== exp) $display("FAIL prio k=%0d got=%b exp=%b", k, got, exp); else passed++;
    end
    bus.req = '0;
    @(negedge clk);
    bus.req = 4'b0001;
    @(negedge clk);
    checks++;
    if (bus.grant !== 4'b0001) $display("FAIL prio_regrant got=%b exp=0001", bus.grant);
    else passed++;
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_continuous;
    logic [8:0] got, exp;
    set_cfg(1, 0, 0);
    bus.req = 4'b0010;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      got = {bus.grant, bus.done, bus.beep_out};
      exp = {4'b0010, 4'b0, lvl(k, 12)};
      checks++;
      if (got !== exp) $display("FAIL cont k=%0d got=%b exp=%b", k, got, exp); else passed++;
    end
    bus.req = '0;
    @(negedge clk);
    got = {bus.grant, bus.done, bus.beep_out};
    checks++;
    if (got !== {4'b0, 4'b0010, 1'b0}) $display("FAIL cont_drop got=%b exp=000000100", got);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [9:0] got;
    set_cfg(0, 3, 1); set_cfg(2, 2, 3);
    bus.req = 4'b0001;
    repeat (7) @(negedge clk);
    checks++;
    if (bus.done !== 4'b0001) $display("FAIL rmid_done0 got=%b exp=0001", bus.done); else passed++;
    bus.req = 4'b0101;
    repeat (2) @(negedge clk);
    got = {bus.grant, bus.busy, bus.done, bus.beep_out};
    checks++;
    if (got !== {4'b0100, 1'b1, 4'b0, 1'b1}) $display("FAIL rmid_on got=%b exp=0100100001", got);
    else passed++;
    #2 rst = 1'b1;
    #1;
    got = {bus.grant, bus.busy, bus.done, bus.beep_out};
    checks++;
    if (got !== 10'd0) $display("FAIL rmid_async got=%b exp=0", got); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.grant !== 4'b0001) $display("FAIL rmid_served got=%b exp=0001", bus.grant); else passed++;
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latched_rate;
    logic [8:0] got, exp;
    set_cfg(0, 3, 1);
    bus.req = 4'b0001;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      exp = (k < 6) ? {4'b0001, 4'b0, lvl(k, 3)} : {4'b0, 4'b0001, 1'b0};
      got = {bus.grant, bus.done, bus.beep_out};
      checks++;
      if (got !== exp) $display("FAIL latch k=%0d got=%b exp=%b", k, got, exp); else passed++;
      if (k == 1) set_cfg(0, 0, 2);
    end
    bus.req = '0;
    @(negedge clk);
    bus.req = 4'b0001;
    for (int k = 0; k <= 48; k++) begin
      @(negedge clk);
      exp = (k < 48) ? {4'b0001, 4'b0, lvl(k, 12)} : {4'b0, 4'b0001, 1'b0};
      got = {bus.grant, bus.done, bus.beep_out};
      checks++;
      if (got !== exp) $display("FAIL relatch k=%0d got=%b exp=%b", k, got, exp); else passed++;
    end
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_preempt;
    logic [12:0] got;
    set_cfg(3, 3, 0); set_cfg(1, 3, 1);
    bus.req = 4'b1000;
    repeat (4) @(negedge clk);
    bus.req = 4'b1010;
`ifdef BEEP_PREEMPT_EN
    @(negedge clk);
    got = {bus.grant, bus.done, bus.abort, bus.beep_out};
    checks++;
    if (got !== {4'b0, 4'b0, 4'b1000, 1'b0}) $display("FAIL pre_abort got=%b exp=0000000010000", got);
    else passed++;
    @(negedge clk);
    checks++;
    if (bus.grant !== 4'b0010) $display("FAIL pre_grant1 got=%b exp=0010", bus.grant); else passed++;
    repeat (6) @(negedge clk);
    checks++;
    if (bus.done !== 4'b0010) $display("FAIL pre_done1 got=%b exp=0010", bus.done); else passed++;
    bus.req = 4'b1000;
    @(negedge clk);
    got = {bus.grant, bus.done, bus.abort, bus.beep_out};
    checks++;
    if (got !== {4'b1000, 4'b0, 4'b0, 1'b1}) $display("FAIL pre_regrant3 got=%b exp=1000000000001", got);
    else passed++;
    bus.req = '0;
`else
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      got = {bus.grant, bus.done, bus.abort, 1'b0};
      checks++;
      if (got !== {4'b1000, 4'b0, 4'b0, 1'b0}) $display("FAIL nopre_wait k=%0d got=%b exp=1000000000000", k, got);
      else passed++;
    end
    bus.req = 4'b0010;
    @(negedge clk);
    checks++;
    if (bus.done !== 4'b1000) $display("FAIL nopre_done3 got=%b exp=1000", bus.done); else passed++;
    @(negedge clk);
    checks++;
    if (bus.grant !== 4'b0010) $display("FAIL nopre_grant1 got=%b exp=0010", bus.grant); else passed++;
    bus.req = '0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL pre_idle got=%b exp=0", bus.busy); else passed++;
  endtask

  initial begin
    test_reset;
    test_sequences;
    test_priority;
    test_continuous;
    test_reset_mid;
    test_latched_rate;
    test_preempt;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
